pipe_ctrl: RTL and testbench

//  Central control for the five-stage Y86-64 pipeline. Detects load/use, ret and mispredicted-jump

---
 rtl/y86_pkg.sv | 30 +++
 rtl/hazard_detect.sv | 26 ++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, one-hot status codes and control FSM states.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE    = 4'hF;

   // One-hot status, bit order {INS, ADR, HLT, AOK}
   localparam logic [3:0] STAT_AOK = 4'b0001;
   localparam logic [3:0] STAT_HLT = 4'b0010;
   localparam logic [3:0] STAT_ADR = 4'b0100;
   localparam logic [3:0] STAT_INS = 4'b1000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/hazard_detect.sv
// Combinational pipeline hazard terms: load/use, ret in flight, mispredicted jump.
module hazard_detect
   import y86_pkg::*;
(
   input  logic [3:0] D_icode,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] E_icode,
   input  logic [3:0] E_dstM,
   input  logic       e_cnd,
   input  logic [3:0] M_icode,
   output logic       lu,
   output logic       ret,
   output logic       mp
);

   logic e_is_load;

   always_comb begin
      e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
      lu  = e_is_load && (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      mp  = (E_icode == I_JXX) && !e_cnd;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble generation, run/drain/halt FSM, perf counters.
module pipe_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned RSP_REG = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_cnd,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic [3:0]       stat,
   output logic             running,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic       lu, ret, mp;
   logic [1:0] state_q, state_d;
   logic [3:0] stat_q, stat_d;
   logic       m_bad, w_bad, ret_bub;

   hazard_detect u_hazard (
      .D_icode (D_icode),
      .d_srcA  (d_srcA),
      .d_srcB  (d_srcB),
      .E_icode (E_icode),
      .E_dstM  (E_dstM),
      .e_cnd   (e_cnd),
      .M_icode (M_icode),
      .lu      (lu),
      .ret     (ret),
      .mp      (mp)
   );

   always_comb begin
      m_bad   = (m_stat != STAT_AOK);
      w_bad   = (W_stat != STAT_AOK);
      ret_bub = ret && !lu;
      running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      stat    = stat_q;

      // Idle and halt freeze the whole pipe
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      if (running) begin
         F_stall  = lu || ret;
         D_stall  = lu;
         D_bubble = mp || ret_bub;
         E_bubble = mp || lu;
         // Once a fault leaves M, nothing younger may touch memory or CCs
         M_bubble = (state_q == ST_DRAIN) || m_bad;
         W_stall  = w_bad;
      end
   end

   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (m_bad) state_d = ST_DRAIN;
         ST_DRAIN: if (w_bad) begin
            state_d = ST_HALT;
            stat_d  = W_stat;
         end
         default:  state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         stat_q      <= STAT_AOK;
         cyc_cnt     <= '0;
         stall_cnt   <= '0;
         mispred_cnt <= '0;
         ret_cnt     <= '0;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
         if (running) begin
            if (cyc_cnt != CNT_MAX)               cyc_cnt     <= cyc_cnt + 1'b1;
            if (lu && stall_cnt != CNT_MAX)       stall_cnt   <= stall_cnt + 1'b1;
            if (mp && mispred_cnt != CNT_MAX)     mispred_cnt <= mispred_cnt + 1'b1;
            if (ret_bub && ret_cnt != CNT_MAX)    ret_cnt     <= ret_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized traffic vs a model.
module tb_pipe_ctrl;

   localparam int unsigned CNT_W = 8;
   localparam longint SAT = (64'd1 << CNT_W) - 1;
   localparam int MD_IDLE = 0, MD_RUN = 1, MD_DRAIN = 2, MD_HALT = 3;

   logic clk = 1'b0;
   logic rst, start, e_cnd;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
   logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, running;
   logic [3:0] stat;
   logic [CNT_W-1:0] cyc_cnt, stall_cnt, mispred_cnt, ret_cnt;

   int n_chk = 0;
   int n_fail = 0;

   int     md;
   logic [3:0] md_stat;
   longint c_cyc, c_stall, c_mp, c_ret;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(CNT_W), .RSP_REG(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .M_bubble(M_bubble), .W_stall(W_stall), .stat(stat), .running(running),
      .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_lu();
      return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
   endfunction

   function automatic bit m_ret();
      return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
   endfunction

   function automatic bit m_mp();
      return E_icode == 4'h7 && !e_cnd;
   endfunction

   task automatic model_reset();
      md = MD_IDLE; md_stat = 4'b0001;
      c_cyc = 0; c_stall = 0; c_mp = 0; c_ret = 0;
   endtask

   function automatic longint sat_inc(input longint v, input bit en);
      return (en && v < SAT) ? v + 1 : v;
   endfunction

   task automatic check_all(input string ctx);
      bit act, lu, rt, mp;
      act = (md == MD_RUN || md == MD_DRAIN);
      lu = m_lu(); rt = m_ret(); mp = m_mp();
      chk({ctx, ".F_stall"},  F_stall,  act ? (lu | rt) : 1'b1);
      chk({ctx, ".D_stall"},  D_stall,  act ? lu : 1'b1);
      chk({ctx, ".D_bubble"}, D_bubble, act ? (mp | (rt & !lu)) : 1'b1);
      chk({ctx, ".E_bubble"}, E_bubble, act ? (mp | lu) : 1'b1);
      chk({ctx, ".M_bubble"}, M_bubble, act ? (md == MD_DRAIN || m_stat != 4'b0001) : 1'b1);
      chk({ctx, ".W_stall"},  W_stall,  act ? (W_stat != 4'b0001) : 1'b1);
      chk({ctx, ".stat"},     stat,     md_stat);
      chk({ctx, ".running"},  running,  act);
      chk({ctx, ".cyc_cnt"},     cyc_cnt,     c_cyc);
      chk({ctx, ".stall_cnt"},   stall_cnt,   c_stall);
      chk({ctx, ".mispred_cnt"}, mispred_cnt, c_mp);
      chk({ctx, ".ret_cnt"},     ret_cnt,     c_ret);
   endtask

   // Check at negedge, then advance the model across the rising edge
   task automatic tick(input string ctx);
      bit act, lu, rt, mp;
      @(negedge clk);
      check_all(ctx);
      act = (md == MD_RUN || md == MD_DRAIN);
      lu = m_lu(); rt = m_ret(); mp = m_mp();
      if (act) begin
         c_cyc   = sat_inc(c_cyc, 1'b1);
         c_stall = sat_inc(c_stall, lu);
         c_mp    = sat_inc(c_mp, mp);
         c_ret   = sat_inc(c_ret, rt && !lu);
      end
      case (md)
         MD_IDLE:  if (start) md = MD_RUN;
         MD_RUN:   if (m_stat != 4'b0001) md = MD_DRAIN;
         MD_DRAIN: if (W_stat != 4'b0001) begin md = MD_HALT; md_stat = W_stat; end
         default:  ;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      start = 0; D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
      m_stat = 4'b0001; W_stat = 4'b0001;
   endtask

   function automatic logic [3:0] rnd_reg();
      int r;
      r = $urandom_range(0, 5);
      return (r == 5) ? 4'hF : 4'(r);
   endfunction

   initial begin
      quiet();
      rst = 1'b1;
      model_reset();
      #12;
      check_all("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      tick("idle");

      // Start then five clean cycles
      start = 1'b1;
      tick("start");
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick("clean");
      chk("cyc5", cyc_cnt, 64'd5);
      chk("run_nohaz_f", F_stall, 1'b0);

      // Load/use
      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
      tick("lu");
      quiet();
      chk("stall_cnt1", stall_cnt, 64'd1);

      // Mispredict
      E_icode = 4'h7; e_cnd = 1'b0;
      tick("mp");
      quiet();
      chk("mispred1", mispred_cnt, 64'd1);

      // ret walking D -> E -> M
      D_icode = 4'h9; tick("retD"); quiet();
      E_icode = 4'h9; tick("retE"); quiet();
      M_icode = 4'h9; tick("retM"); quiet();
      chk("ret3", ret_cnt, 64'd3);

      // Randomized traffic, status kept AOK
      for (int i = 0; i < 150; i++) begin
         D_icode = 4'($urandom_range(0, 11));
         E_icode = 4'($urandom_range(0, 11));
         M_icode = 4'($urandom_range(0, 11));
         d_srcA = rnd_reg(); d_srcB = rnd_reg(); E_dstM = rnd_reg();
         e_cnd = 1'($urandom_range(0, 1));
         tick("rand");
      end
      quiet();

      // Fault leaves M, then reaches W
      m_stat = 4'b0100;
      tick("mfault");
      m_stat = 4'b0001; W_stat = 4'b0100;
      D_icode = 4'h9;
      tick("drain");
      quiet(); W_stat = 4'b0100;
      tick("halt");
      chk("halt_stat", stat, 64'h4);
      chk("halt_run", running, 1'b0);
      start = 1'b1;
      tick("halt_start");
      start = 1'b0;
      tick("halt_after");

      // Saturation under a held load/use
      rst = 1'b1; #1; model_reset();
      check_all("rst2");
      rst = 1'b0;
      quiet(); start = 1'b1;
      tick("start2");
      start = 1'b0;
      E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2;
      for (int i = 0; i < 300; i++) tick("sat");
      chk("sat_stall", stall_cnt, SAT);
      chk("sat_cyc", cyc_cnt, SAT);

      // Reset mid-run: immediate
      rst = 1'b1; #1; model_reset();
      check_all("rst_mid");
      chk("rst_mid_cnt", stall_cnt, 64'd0);
      rst = 1'b0;
      tick("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
